// File: rtl/click_pipe_ctrl_pkg.sv
// Shared constants for the click-style token pipeline controller.
package click_pipe_ctrl_pkg;

    // Default depth matches the classic IF/ID/EX/MEM/WB pipeline
    localparam int N_STAGE_DEF = 5;

    // Stage indices for the default five-stage configuration
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/click_stage_ctrl.sv
// One pipeline stage of the click controller: full flag, click phase and
// the local accept/fire decision.
module click_stage_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic src,       // upstream offers a token to this stage
    input  logic leave,     // the token held here moves on this cycle
    input  logic stall,     // block entry into this stage
    input  logic flush,     // this stage is covered by the flush mask
    output logic acc,       // stage can take a token this cycle
    output logic fire,      // token enters this stage this cycle
    output logic full_nxt,  // full flag after this cycle
    output logic full,
    output logic phase
);

    // A flushed stage is always free to accept but never loads in the flush cycle
    assign acc      = ~full | leave | flush;
    assign fire     = src & acc & ~stall & ~flush;
    assign full_nxt = fire | (full & ~leave & ~flush);

    // Hold the occupancy flag and toggle the click phase on every fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            phase <= 1'b0;
        end else begin
            full  <= full_nxt;
            phase <= phase ^ fire;
        end
    end

endmodule

// File: rtl/click_pipe_ctrl.sv
// Parametrised N-stage click pipeline controller with per-stage stall and
// flush, valid/ready handshakes at both ends and an occupancy count.
// o_fire[k] is the load enable for stage k's datapath register.
import click_pipe_ctrl_pkg::*;

module click_pipe_ctrl #(
    parameter  int N_STAGE = N_STAGE_DEF,
    localparam int CNT_W   = $clog2(N_STAGE + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    input  logic [N_STAGE-1:0] i_stall,
    input  logic [N_STAGE-1:0] i_flush,
    output logic [N_STAGE-1:0] o_fire,
    output logic [N_STAGE-1:0] o_full,
    output logic [N_STAGE-1:0] o_phase,
    output logic [CNT_W-1:0]   o_count
);

    logic [N_STAGE-1:0] flush_mask;
    logic [N_STAGE-1:0] src;
    logic [N_STAGE-1:0] leave;
    logic [N_STAGE-1:0] acc;
    logic [N_STAGE-1:0] full_nxt;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_STAGE-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_STAGE; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // A flush request on stage k discards everything from stage k back to IF
    always_comb begin
        logic run;
        run        = 1'b0;
        flush_mask = '0;
        for (int j = N_STAGE - 1; j >= 0; j--) begin
            run           = run | i_flush[j];
            flush_mask[j] = run;
        end
    end

    // Source offers: IF takes from upstream, others from the previous stage
    assign src = {o_full[N_STAGE-2:0] & ~flush_mask[N_STAGE-2:0],
                  i_in_valid & ~flush_mask[0]};

    // Ripple readiness from WB back to IF so a full pipe advances in one cycle;
    // a stage's token leaves exactly when the next stage fires
    always_comb begin
        logic nxt;
        nxt   = o_full[N_STAGE-1] & i_out_ready;
        leave = '0;
        for (int k = N_STAGE - 1; k >= 0; k--) begin
            leave[k] = nxt;
            nxt = src[k] & (~o_full[k] | nxt | flush_mask[k])
                & ~i_stall[k] & ~flush_mask[k];
        end
    end

    for (genvar k = 0; k < N_STAGE; k++) begin : g_stage
        click_stage_ctrl u_stage (
            .clk      (i_clk),
            .rst      (i_rst),
            .src      (src[k]),
            .leave    (leave[k]),
            .stall    (i_stall[k]),
            .flush    (flush_mask[k]),
            .acc      (acc[k]),
            .fire     (o_fire[k]),
            .full_nxt (full_nxt[k]),
            .full     (o_full[k]),
            .phase    (o_phase[k])
        );
    end

    // Independent of i_in_valid so no combinational path loops through upstream
    assign o_in_ready  = acc[STG_IF] & ~i_stall[STG_IF] & ~flush_mask[STG_IF];
    assign o_out_valid = o_full[N_STAGE-1];

    // Count follows the next full vector so it agrees with o_full every cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
        end else begin
            o_count <= popcount(full_nxt);
        end
    end

endmodule

// File: tb/tb_click_pipe_ctrl.sv
// Self-checking bench for click_pipe_ctrl (five stages). Each token gets a
// sequence number when it enters IF; a shadow data pipeline loaded by o_fire
// carries it to WB, where it must retire in the order it was queued.
module tb_click_pipe_ctrl;

    localparam int N = 5;

    logic         i_clk;
    logic         i_rst;
    logic         i_in_valid;
    logic         o_in_ready;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [N-1:0] i_stall;
    logic [N-1:0] i_flush;
    logic [N-1:0] o_fire;
    logic [N-1:0] o_full;
    logic [N-1:0] o_phase;
    logic [2:0]   o_count;

    int errors = 0;
    int checks = 0;

    int sb_q[$];
    int mdl [N];
    int next_tok = 0;
    int exp_tok;

    click_pipe_ctrl #(.N_STAGE(N)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .o_fire      (o_fire),
        .o_full      (o_full),
        .o_phase     (o_phase),
        .o_count     (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Scoreboard: sample mid-cycle what the coming edge will do
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_out_valid && i_out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL retire_order: token %0d retired, none expected", mdl[N-1]);
                end else begin
                    exp_tok = sb_q.pop_front();
                    if (mdl[N-1] !== exp_tok) begin
                        errors++;
                        $display("FAIL retire_order: got token %0d want %0d", mdl[N-1], exp_tok);
                    end
                end
            end
            for (int k = N - 1; k > 0; k--) begin
                if (o_fire[k]) mdl[k] = mdl[k-1];
            end
            if (o_fire[0]) begin
                mdl[0] = next_tok;
                sb_q.push_back(next_tok);
                next_tok++;
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill_pipe();
        int i;
        i_in_valid  = 1'b1;
        i_out_ready = 1'b0;
        i = 0;
        while (o_full !== 5'b11111 && i < 20) begin
            tick();
            i++;
        end
        checks++;
        if (o_full !== 5'b11111) begin
            errors++;
            $display("FAIL fill_timeout: full=%b want 11111", o_full);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b0;
        i_stall = '0; i_flush = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_full !== 5'b00000) begin errors++; $display("FAIL reset_full: got %b want 00000", o_full); end
        checks++; if (o_phase !== 5'b00000) begin errors++; $display("FAIL reset_phase: got %b want 00000", o_phase); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
        checks++; if (o_fire !== 5'b00000) begin errors++; $display("FAIL reset_fire: got %b want 00000", o_fire); end
        i_rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic [N-1:0] exp_f;
        logic [N-1:0] exp_ph;
        exp_ph = '0;
        i_in_valid = 1'b1; i_out_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            exp_f = (c >= N) ? 5'b11111 : 5'((1 << c) - 1);
            #1;
            checks++; if (o_fire !== exp_f) begin errors++; $display("FAIL stream_fire c%0d: got %b want %b", c, o_fire, exp_f); end
            tick();
            exp_ph = exp_ph ^ exp_f;
            checks++; if (o_phase !== exp_ph) begin errors++; $display("FAIL stream_phase c%0d: got %b want %b", c, o_phase, exp_ph); end
        end
        checks++; if (o_count !== 3'd5) begin errors++; $display("FAIL stream_count: got %0d want 5", o_count); end
        checks++; if (o_full !== 5'b11111) begin errors++; $display("FAIL stream_full: got %b want 11111", o_full); end
    endtask

    task automatic test_backpressure();
        i_out_ready = 1'b0;
        #1;
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", o_in_ready); end
        checks++; if (o_fire !== 5'b00000) begin errors++; $display("FAIL bp_fire: got %b want 00000", o_fire); end
        repeat (2) begin
            tick();
            checks++; if (o_full !== 5'b11111) begin errors++; $display("FAIL bp_full_hold: got %b want 11111", o_full); end
            checks++; if (o_count !== 3'd5) begin errors++; $display("FAIL bp_count_hold: got %0d want 5", o_count); end
        end
        i_out_ready = 1'b1;
        #1;
        checks++; if (o_fire !== 5'b11111) begin errors++; $display("FAIL bp_release_fire: got %b want 11111", o_fire); end
        tick();
        checks++; if (o_full !== 5'b11111) begin errors++; $display("FAIL bp_release_full: got %b want 11111", o_full); end
    endtask

    task automatic test_mid_stall();
        logic [N-1:0] exp_f  [3];
        logic [N-1:0] exp_fl [3];
        exp_f  = '{5'b11000, 5'b10000, 5'b00000};
        exp_fl = '{5'b11011, 5'b10011, 5'b00011};
        i_in_valid = 1'b1; i_out_ready = 1'b1;
        i_stall = 5'b00100;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (o_fire !== exp_f[c]) begin errors++; $display("FAIL stall_fire c%0d: got %b want %b", c, o_fire, exp_f[c]); end
            checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, o_in_ready); end
            tick();
            checks++; if (o_full !== exp_fl[c]) begin errors++; $display("FAIL stall_full c%0d: got %b want %b", c, o_full, exp_fl[c]); end
        end
        i_stall = '0;
        #1;
        checks++; if (o_fire !== 5'b00111) begin errors++; $display("FAIL stall_release_fire: got %b want 00111", o_fire); end
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready: got %b want 1", o_in_ready); end
        tick();
        checks++; if (o_full !== 5'b00111) begin errors++; $display("FAIL stall_release_full: got %b want 00111", o_full); end
        checks++; if (o_count !== 3'd3) begin errors++; $display("FAIL stall_release_count: got %0d want 3", o_count); end
    endtask

    task automatic test_flush();
        fill_pipe();
        i_flush = 5'b00100;
        #1;
        checks++; if (o_fire !== 5'b00000) begin errors++; $display("FAIL flush_fire: got %b want 00000", o_fire); end
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", o_in_ready); end
        tick();
        i_flush = '0;
        // the three youngest tokens were discarded
        repeat (3) void'(sb_q.pop_back());
        checks++; if (o_full !== 5'b11000) begin errors++; $display("FAIL flush_full: got %b want 11000", o_full); end
        checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL flush_count: got %0d want 2", o_count); end
    endtask

    task automatic test_flush_stall_retire();
        fill_pipe();
        i_flush = 5'b10000; i_stall = 5'b10000; i_out_ready = 1'b1;
        #1;
        checks++; if (o_fire !== 5'b00000) begin errors++; $display("FAIL fsr_fire: got %b want 00000", o_fire); end
        checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL fsr_out_valid: got %b want 1", o_out_valid); end
        tick();
        i_flush = '0; i_stall = '0;
        // WB token retired through the scoreboard; the rest were discarded
        sb_q.delete();
        checks++; if (o_full !== 5'b00000) begin errors++; $display("FAIL fsr_full: got %b want 00000", o_full); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL fsr_count: got %0d want 0", o_count); end
    endtask

    task automatic test_async_reset();
        i_in_valid = 1'b1; i_out_ready = 1'b1;
        repeat (3) tick();
        #3;
        i_rst = 1'b1;
        #1;
        checks++; if (o_full !== 5'b00000) begin errors++; $display("FAIL areset_full: got %b want 00000", o_full); end
        checks++; if (o_phase !== 5'b00000) begin errors++; $display("FAIL areset_phase: got %b want 00000", o_phase); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", o_count); end
        sb_q.delete();
        tick();
        i_rst = 1'b0;
        #1;
        checks++; if (o_fire !== 5'b00001) begin errors++; $display("FAIL areset_first_fire: got %b want 00001", o_fire); end
        tick();
        checks++; if (o_full !== 5'b00001) begin errors++; $display("FAIL areset_full_after: got %b want 00001", o_full); end
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL areset_count_after: got %0d want 1", o_count); end
    endtask

    task automatic test_drain();
        i_in_valid = 1'b0; i_out_ready = 1'b1;
        repeat (8) tick();
        checks++; if (o_full !== 5'b00000) begin errors++; $display("FAIL drain_full: got %b want 00000", o_full); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", o_count); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL drain_pending: got %0d tokens want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_mid_stall();
        test_flush();
        test_flush_stall_retire();
        test_async_reset();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
